// File: rtl/smart_store_pkg.sv
// Shared types and constants for the smart-store datapath: coin codes, the
// denomination table, the checkout state encoding and the greedy change helper.
package smart_store_pkg;

  localparam int DEFAULT_COST_W = 10;

  typedef logic [2:0] coin_code_t;

  localparam logic [9:0] DENOM [0:7] = '{10'd1, 10'd2, 10'd5, 10'd10,
                                         10'd20, 10'd50, 10'd100, 10'd500};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Largest denomination not exceeding value; code 0 when value is 0.
  function automatic coin_code_t greedy_code(input logic [31:0] value);
    coin_code_t code;
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ({22'd0, DENOM[i]} <= value) begin
        code = coin_code_t'(i);
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: loads an amount on start, then offers one coin per
// ready/valid handshake until the remainder is zero, and pulses done.
module change_dispenser
  import smart_store_pkg::*;
#(
  parameter int PAY_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [PAY_W-1:0] amount_i,
  input  logic             coin_out_ready_i,
  output logic             coin_out_valid_o,
  output coin_code_t       coin_out_code_o,
  output logic             done_o
);

  logic [PAY_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  coin_code_t       code_q, code_d;
  logic             done_q, done_d;
  logic             take_s;

  // Remainder update and selection of the next offered coin.
  always_comb begin
    rem_d   = rem_q;
    valid_d = valid_q;
    code_d  = code_q;
    done_d  = 1'b0;
    take_s  = valid_q && coin_out_ready_i;
    if (start_i) begin
      rem_d = amount_i;
    end else if (take_s) begin
      rem_d = rem_q - PAY_W'(DENOM[code_q]);
    end else begin
      rem_d = rem_q;
    end
    // Code only changes on load or handshake, so it is stable while waiting.
    if (start_i || take_s) begin
      valid_d = (rem_d != {PAY_W{1'b0}});
      code_d  = greedy_code(32'(rem_d));
      done_d  = (rem_d == {PAY_W{1'b0}});
    end else begin
      valid_d = valid_q;
      code_d  = code_q;
    end
  end

  // Dispenser state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= {PAY_W{1'b0}};
      valid_q <= 1'b0;
      code_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign coin_out_valid_o = valid_q;
  assign coin_out_code_o  = code_q;
  assign done_o           = done_q;

endmodule

// File: rtl/checkout_billing.sv
// Checkout stage: latches the trolley total, collects coins, then dispenses
// change (bill) or the full payment (refund) through the shared dispenser.
module checkout_billing
  import smart_store_pkg::*;
#(
  parameter int COST_W      = DEFAULT_COST_W,
  parameter int PAY_W       = 12,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              checkout_req,
  input  logic [COST_W-1:0] total_cost,
  input  logic              cancel,
  input  logic              coin_valid,
  input  logic [2:0]        coin_code,
  input  logic              coin_out_ready,
  output logic              busy,
  output logic [COST_W-1:0] amount_due,
  output logic [PAY_W-1:0]  paid,
  output logic              coin_reject,
  output logic              coin_out_valid,
  output logic [2:0]        coin_out_code,
  output logic              bill_done,
  output logic              refund_done,
  output logic              timeout,
  output logic              trolley_clear
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state_q, state_d;
  logic [COST_W-1:0] amount_q, amount_d;
  logic [PAY_W-1:0]  paid_q, paid_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              refund_q, refund_d;
  logic              busy_q, busy_d;
  logic              reject_q, reject_d;
  logic              timeout_q, timeout_d;
  logic              bill_q, bill_d;
  logic              refund_done_q, refund_done_d;
  logic              clear_q, clear_d;
  logic              disp_start_s;
  logic [PAY_W-1:0]  disp_amount_s;
  logic              disp_done_s;
  logic              expire_s;

  change_dispenser #(.PAY_W(PAY_W)) u_dispenser (
    .clk              (clk),
    .rst_n            (reset),
    .start_i          (disp_start_s),
    .amount_i         (disp_amount_s),
    .coin_out_ready_i (coin_out_ready),
    .coin_out_valid_o (coin_out_valid),
    .coin_out_code_o  (coin_out_code),
    .done_o           (disp_done_s)
  );

  // Checkout FSM next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    amount_d      = amount_q;
    paid_d        = paid_q;
    timer_d       = timer_q;
    refund_d      = refund_q;
    timeout_d     = 1'b0;
    bill_d        = 1'b0;
    refund_done_d = 1'b0;
    clear_d       = 1'b0;
    disp_start_s  = 1'b0;
    disp_amount_s = {PAY_W{1'b0}};
    reject_d      = coin_valid && (state_q != ST_COLLECT);
    expire_s      = !coin_valid && (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    case (state_q)
      ST_IDLE: begin
        if (checkout_req) begin
          if (total_cost != {COST_W{1'b0}}) begin
            amount_d = total_cost;
            paid_d   = {PAY_W{1'b0}};
            timer_d  = {TMR_W{1'b0}};
            state_d  = ST_COLLECT;
          end else begin
            bill_d  = 1'b1;
            clear_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (coin_valid) begin
          paid_d  = paid_q + PAY_W'(DENOM[coin_code]);
          timer_d = {TMR_W{1'b0}};
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
        // A coin landing with cancel/timeout is part of the refund via paid_d.
        if (cancel) begin
          refund_d      = 1'b1;
          disp_start_s  = 1'b1;
          disp_amount_s = paid_d;
          state_d       = ST_DISPENSE;
        end else if (paid_q >= PAY_W'(amount_q)) begin
          state_d = ST_SETTLE;
        end else if (expire_s) begin
          timeout_d     = 1'b1;
          refund_d      = 1'b1;
          disp_start_s  = 1'b1;
          disp_amount_s = paid_d;
          state_d       = ST_DISPENSE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_SETTLE: begin
        refund_d      = 1'b0;
        disp_start_s  = 1'b1;
        disp_amount_s = paid_q - PAY_W'(amount_q);
        state_d       = ST_DISPENSE;
      end
      ST_DISPENSE: begin
        if (disp_done_s) begin
          state_d = ST_DONE;
          if (refund_q) begin
            refund_done_d = 1'b1;
          end else begin
            bill_d  = 1'b1;
            clear_d = 1'b1;
          end
        end else begin
          state_d = ST_DISPENSE;
        end
      end
      ST_DONE: begin
        amount_d = {COST_W{1'b0}};
        timer_d  = {TMR_W{1'b0}};
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Checkout state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      amount_q      <= {COST_W{1'b0}};
      paid_q        <= {PAY_W{1'b0}};
      timer_q       <= {TMR_W{1'b0}};
      refund_q      <= 1'b0;
      busy_q        <= 1'b0;
      reject_q      <= 1'b0;
      timeout_q     <= 1'b0;
      bill_q        <= 1'b0;
      refund_done_q <= 1'b0;
      clear_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      amount_q      <= amount_d;
      paid_q        <= paid_d;
      timer_q       <= timer_d;
      refund_q      <= refund_d;
      busy_q        <= busy_d;
      reject_q      <= reject_d;
      timeout_q     <= timeout_d;
      bill_q        <= bill_d;
      refund_done_q <= refund_done_d;
      clear_q       <= clear_d;
    end
  end

  assign busy          = busy_q;
  assign amount_due    = amount_q;
  assign paid          = paid_q;
  assign coin_reject   = reject_q;
  assign timeout       = timeout_q;
  assign bill_done     = bill_q;
  assign refund_done   = refund_done_q;
  assign trolley_clear = clear_q;

endmodule

// File: tb/tb_checkout_billing.sv
// Scoreboard bench for checkout_billing: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_checkout_billing;

  localparam int COST_W = 10;
  localparam int PAY_W  = 12;

  localparam logic [2:0] EV_COIN    = 3'd1;
  localparam logic [2:0] EV_BILL    = 3'd2;
  localparam logic [2:0] EV_REFUND  = 3'd3;
  localparam logic [2:0] EV_TIMEOUT = 3'd4;
  localparam logic [2:0] EV_REJECT  = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic [2:0] code;
    logic       clr;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              checkout_req, cancel, coin_valid, coin_out_ready;
  logic [COST_W-1:0] total_cost;
  logic [2:0]        coin_code;
  logic              busy, coin_reject, coin_out_valid;
  logic              bill_done, refund_done, timeout, trolley_clear;
  logic [COST_W-1:0] amount_due;
  logic [PAY_W-1:0]  paid;
  logic [2:0]        coin_out_code;

  int  errors = 0;
  int  checks = 0;
  ev_t sb[$];

  always #5 clk = ~clk;

  checkout_billing #(.COST_W(COST_W), .PAY_W(PAY_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(rst_n), .checkout_req(checkout_req), .total_cost(total_cost),
    .cancel(cancel), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_out_ready(coin_out_ready), .busy(busy), .amount_due(amount_due),
    .paid(paid), .coin_reject(coin_reject), .coin_out_valid(coin_out_valid),
    .coin_out_code(coin_out_code), .bill_done(bill_done), .refund_done(refund_done),
    .timeout(timeout), .trolley_clear(trolley_clear)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_ev(input ev_t got);
    ev_t exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d code=%0d clr=%0d, none expected",
               got.kind, got.code, got.clr);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL event: got kind=%0d code=%0d clr=%0d expected kind=%0d code=%0d clr=%0d",
                 got.kind, got.code, got.clr, exp.kind, exp.code, exp.clr);
      end
    end
  endtask

  // Monitor: one comparison per presented event, in a fixed per-cycle order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (timeout)                         check_ev('{EV_TIMEOUT, 3'd0, trolley_clear});
      if (coin_reject)                     check_ev('{EV_REJECT, 3'd0, trolley_clear});
      if (coin_out_valid && coin_out_ready) check_ev('{EV_COIN, coin_out_code, trolley_clear});
      if (bill_done)                       check_ev('{EV_BILL, 3'd0, trolley_clear});
      if (refund_done)                     check_ev('{EV_REFUND, 3'd0, trolley_clear});
      if (trolley_clear && !bill_done) begin
        checks++;
        errors++;
        $display("FAIL clear_alone: trolley_clear=1 bill_done=0, expected clear only with bill_done");
      end
    end
  end

  task automatic push(input logic [2:0] kind, input logic [2:0] code, input logic clr);
    sb.push_back('{kind, code, clr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkout(input logic [COST_W-1:0] cost);
    checkout_req = 1'b1;
    total_cost   = cost;
    step();
    checkout_req = 1'b0;
  endtask

  task automatic coin(input logic [2:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {63'd0, ok}, 64'd1);
    step();
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (coin_out_valid) break;
    end
    chk(name, {63'd0, coin_out_valid}, 64'd1);
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; checkout_req = 1'b0; cancel = 1'b0; coin_valid = 1'b0;
    coin_code = 3'd0; coin_out_ready = 1'b1; total_cost = '0;
    #3;
    chk("reset_outputs", {busy, amount_due, paid, coin_reject, coin_out_valid, coin_out_code,
                          bill_done, refund_done, timeout, trolley_clear}, 64'd0);
    #19 rst_n = 1'b1;
    step();

    // 1: exact payment, no change
    push(EV_BILL, 3'd0, 1'b1);
    checkout(10'd10);
    chk("t1_amount_due", {54'd0, amount_due}, 64'd10);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    coin(3'd3);
    wait_drain("t1_drain", 40);

    // 2: 100 against 81 -> change 10,5,2,2 on consecutive cycles
    push(EV_COIN, 3'd3, 1'b0); push(EV_COIN, 3'd2, 1'b0);
    push(EV_COIN, 3'd1, 1'b0); push(EV_COIN, 3'd1, 1'b0);
    push(EV_BILL, 3'd0, 1'b1);
    checkout(10'd81);
    coin(3'd6);
    wait_valid("t2_valid_seen");
    cnt = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (coin_out_valid) cnt++;
    end
    chk("t2_consecutive", cnt, 64'd4);
    @(negedge clk);
    chk("t2_valid_drop", {63'd0, coin_out_valid}, 64'd0);
    wait_drain("t2_drain", 40);

    // 3: cancel refunds the 50 paid
    push(EV_COIN, 3'd5, 1'b0);
    push(EV_REFUND, 3'd0, 1'b0);
    checkout(10'd55);
    coin(3'd5);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    wait_drain("t3_drain", 40);

    // 4: timeout after 16 idle cycles, refund the 5
    push(EV_TIMEOUT, 3'd0, 1'b0);
    push(EV_COIN, 3'd2, 1'b0);
    push(EV_REFUND, 3'd0, 1'b0);
    checkout(10'd7);
    coin(3'd2);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (timeout) cnt++;
    end
    chk("t4_no_early_timeout", cnt, 64'd0);
    @(negedge clk);
    chk("t4_timeout_pulse", {63'd0, timeout}, 64'd1);
    wait_drain("t4_drain", 40);

    // 5: zero-cost checkout and a coin in IDLE
    push(EV_BILL, 3'd0, 1'b1);
    checkout(10'd0);
    @(negedge clk);
    chk("t5_zero_bill", {62'd0, bill_done, trolley_clear}, 64'd3);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    chk("t5_busy_never", cnt, 64'd0);
    step();
    push(EV_REJECT, 3'd0, 1'b0);
    coin(3'd4);
    @(negedge clk);
    chk("t5_paid_unchanged", {52'd0, paid}, 64'd5);
    wait_drain("t5_drain", 20);

    // 6: change held while ready low, then reset mid-dispense
    coin_out_ready = 1'b0;
    checkout(10'd81);
    coin(3'd6);
    wait_valid("t6_valid_seen");
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (coin_out_valid && coin_out_code == 3'd3) cnt++;
    end
    chk("t6_code_stable", cnt, 64'd5);
    chk("t6_paid", {52'd0, paid}, 64'd100);
    chk("t6_amount_due", {54'd0, amount_due}, 64'd81);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {busy, amount_due, paid, coin_reject, coin_out_valid, coin_out_code,
                             bill_done, refund_done, timeout, trolley_clear}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    coin_out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t6_idle_after_reset", {62'd0, busy, coin_out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
